mem_ctrl: RTL and testbench

// - Memory-side bus slave for the multicycle CPU. Consumes Memread/Memwrite/Addr and the shared
//   32-bit BUS, and returns read data on BUS.
// - Backs a word-addressed RAM with a 2-entry posted-write buffer and a small memory-mapped I/O

---
 rtl/mem_ctrl.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory-side bus slave for the multicycle CPU.
// Word-addressed RAM behind a posted-write buffer, plus a small IO window
// (LED register, synchronised switches, free-running cycle counter).
// Reads are combinational and forward from the write buffer (newest wins).
// WBDEPTH must be 2 or 4 (pointers wrap as powers of two).
//
// Ports:
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   Memread  CPU read strobe
//   Memwrite CPU write strobe (CPU drives BUS while high)
//   Addr     CPU byte address; [31:28]==F selects IO, else RAM index Addr[AW+1:2]
//   BUS      shared 32-bit data bus; driven only for a clean read
//   io_sw    board switches (asynchronous)
//   io_led   LED register
//   wb_ovf   sticky error: write dropped on a full buffer, or both strobes high
module mem_ctrl #(
  parameter int unsigned AW      = 10,
  parameter int unsigned WBDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Memread,
  input  logic        Memwrite,
  input  logic [31:0] Addr,
  inout  wire  [31:0] BUS,
  input  logic [15:0] io_sw,
  output logic [15:0] io_led,
  output logic        wb_ovf
);

  localparam int unsigned PW        = $clog2(WBDEPTH);
  localparam int unsigned CW        = $clog2(WBDEPTH + 1);
  localparam int unsigned RAM_WORDS = 2 ** AW;
  localparam logic [25:0] OFF_LED   = 26'd0;
  localparam logic [25:0] OFF_SW    = 26'd1;
  localparam logic [25:0] OFF_CNT   = 26'd2;

  // Address decode
  logic          is_io;
  logic [AW-1:0] idx;
  logic [25:0]   io_off;
  logic          unused_addr_lsb;

  assign is_io           = (Addr[31:28] == 4'hF);
  assign idx             = Addr[AW+1:2];
  assign io_off          = Addr[27:2];
  assign unused_addr_lsb = ^Addr[1:0];

  // State
  logic [15:0]   led_q, led_d;
  logic [31:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [15:0]   sw_meta_q, sw_sync_q;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [AW-1:0] wb_idx_q  [WBDEPTH];
  logic [31:0]   wb_data_q [WBDEPTH];
  logic [31:0]   ram_q     [RAM_WORDS];

  // Control
  logic rd_req, push_req, do_drain, buf_full, do_push, do_drop, led_wr, cnt_wr;

  always_comb begin
    rd_req   = Memread && !Memwrite;
    push_req = Memwrite && !is_io;
    // Single-port RAM: reads own the port, so draining waits for Memread low.
    do_drain = !Memread && (count_q != '0);
    buf_full = (count_q == CW'(WBDEPTH));
    // A full buffer that drains this edge frees the slot the push lands in.
    do_push  = push_req && (!buf_full || do_drain);
    do_drop  = push_req && buf_full && !do_drain;
    led_wr   = Memwrite && is_io && (io_off == OFF_LED);
    cnt_wr   = Memwrite && is_io && (io_off == OFF_CNT);
  end

  // Read data: walk oldest to newest so the newest matching entry wins
  logic [31:0]   ram_fwd;
  logic [31:0]   rdata;
  logic [PW-1:0] slot;

  always_comb begin
    ram_fwd = ram_q[idx];
    slot    = head_q;
    for (int unsigned i = 0; i < WBDEPTH; i++) begin
      slot = head_q + PW'(i);
      if ((CW'(i) < count_q) && (wb_idx_q[slot] == idx)) begin
        ram_fwd = wb_data_q[slot];
      end
    end
  end

  always_comb begin
    rdata = ram_fwd;
    if (is_io) begin
      rdata = 32'h0;
      if (io_off == OFF_LED) rdata = {16'h0, led_q};
      if (io_off == OFF_SW)  rdata = {16'h0, sw_sync_q};
      if (io_off == OFF_CNT) rdata = cnt_q;
    end
  end

  // Bus is released during reset and for anything but a clean read
  assign BUS = (rst && rd_req) ? rdata : 32'bz;

  // Next state
  always_comb begin
    led_d   = led_q;
    cnt_d   = cnt_q + 32'd1;
    ovf_d   = ovf_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CW'(do_push) - CW'(do_drain);
    if (led_wr) led_d = BUS[15:0];
    if (cnt_wr) cnt_d = 32'h0;
    if (do_drop || (Memread && Memwrite)) ovf_d = 1'b1;
    if (do_drain) head_d = head_q + PW'(1);
    if (do_push)  tail_d = tail_q + PW'(1);
  end

  // Control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
    end else begin
      led_q     <= led_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sw_meta_q <= io_sw;
      sw_sync_q <= sw_meta_q;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
    end
  end

  // Buffer payload storage; validity is tracked by count_q alone
  always_ff @(posedge clk) begin
    if (do_push) begin
      wb_idx_q[tail_q]  <= idx;
      wb_data_q[tail_q] <= BUS;
    end
  end

  // RAM array, written only by the drain
  always_ff @(posedge clk) begin
    if (do_drain) begin
      ram_q[wb_idx_q[head_q]] <= wb_data_q[head_q];
    end
  end

  assign io_led = led_q;
  assign wb_ovf = ovf_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: directed scenarios plus randomized traffic against
// a queue/associative-array model of the visible memory and write buffer.
module tb_mem_ctrl;

  localparam int AW  = 10;
  localparam int WBD = 2;

  typedef struct packed {
    logic [AW-1:0] idx;
    logic [31:0]   data;
  } wb_ent_t;

  logic        clk;
  logic        rst;
  logic        Memread;
  logic        Memwrite;
  logic [31:0] Addr;
  wire  [31:0] bus;
  logic [15:0] io_sw;
  logic [15:0] io_led;
  logic        wb_ovf;

  logic        tb_oe;
  logic [31:0] tb_dout;
  assign bus = tb_oe ? tb_dout : 32'bz;

  mem_ctrl #(.AW(AW), .WBDEPTH(WBD)) dut (
    .clk      (clk),
    .rst      (rst),
    .Memread  (Memread),
    .Memwrite (Memwrite),
    .Addr     (Addr),
    .BUS      (bus),
    .io_sw    (io_sw),
    .io_led   (io_led),
    .wb_ovf   (wb_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model
  logic [31:0] vis   [int];   // latest accepted write per index
  logic [31:0] ram_m [int];   // what the RAM array holds after drains
  wb_ent_t     pend  [$];     // posted writes not yet drained
  logic [15:0] led_m;
  logic [31:0] cnt_m;
  logic        ovf_m;
  logic [15:0] sw1, sw2;

  logic [31:0] exp_bus;
  logic [31:0] bus_seen;

  task automatic model_reset();
    led_m = 16'h0; cnt_m = 32'h0; ovf_m = 1'b0; sw1 = 16'h0; sw2 = 16'h0;
    pend.delete();
    vis = ram_m;
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    logic [AW-1:0] ix;
    if (a[31:28] == 4'hF) begin
      if (a[27:2] == 26'd0) return {16'h0, led_m};
      if (a[27:2] == 26'd1) return {16'h0, sw2};
      if (a[27:2] == 26'd2) return cnt_m;
      return 32'h0;
    end
    ix = a[AW+1:2];
    if (vis.exists(int'(ix))) return vis[int'(ix)];
    return 32'h0;
  endfunction

  task automatic model_edge(input logic rd, input logic wr,
                            input logic [31:0] a, input logic [31:0] d);
    wb_ent_t e;
    bit      cnt_clr;
    cnt_clr = 1'b0;
    if (!rd && pend.size() > 0) begin
      e = pend.pop_front();
      ram_m[int'(e.idx)] = e.data;
    end
    if (wr) begin
      if (a[31:28] == 4'hF) begin
        if (a[27:2] == 26'd0) led_m = d[15:0];
        if (a[27:2] == 26'd2) cnt_clr = 1'b1;
      end else if (pend.size() < WBD) begin
        e.idx  = a[AW+1:2];
        e.data = d;
        pend.push_back(e);
        vis[int'(e.idx)] = d;
      end else begin
        ovf_m = 1'b1;
      end
    end
    if (rd && wr) ovf_m = 1'b1;
    cnt_m = cnt_clr ? 32'h0 : cnt_m + 32'd1;
    sw2 = sw1;
    sw1 = io_sw;
  endtask

  // One bus cycle: drive just after negedge, sample bus, clock, step model
  task automatic do_cycle(input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d);
    Memread = rd; Memwrite = wr; Addr = a;
    tb_oe = wr; tb_dout = d;
    exp_bus = model_read(a);
    #2;
    bus_seen = bus;
    @(posedge clk);
    model_edge(rd, wr, a, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) do_cycle(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    rst = 1'b0; io_sw = 16'h0;
    Memread = 1'b1; Memwrite = 1'b0; Addr = 32'h40;
    tb_oe = 1'b1; tb_dout = 32'hA5C3_5A3C;
    repeat (2) @(negedge clk);
    #2;
    vectors++;
    if (bus !== 32'hA5C3_5A3C) begin
      miscompares++;
      $display("FAIL reset_bus_released: got %h expected %h", bus, 32'hA5C3_5A3C);
    end
    vectors++;
    if (io_led !== 16'h0) begin
      miscompares++;
      $display("FAIL reset_led: got %h expected %h", io_led, 16'h0);
    end
    vectors++;
    if (wb_ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: got %b expected 0", wb_ovf);
    end
    Memread = 1'b0; tb_oe = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    do_cycle(1'b1, 1'b0, 32'hF000_0008, 32'h0);
    vectors++;
    if (bus_seen !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_counter_first_read: got %h expected %h", bus_seen, 32'h0);
    end
  endtask

  task automatic test_ram_rw();
    do_cycle(1'b0, 1'b1, 32'h10, 32'h1234_5678);
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    vectors++;
    if (bus_seen !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL ram_read_forwarded: got %h expected %h", bus_seen, 32'h1234_5678);
    end
    idle(1);
    vectors++;
    if (dut.ram_q[4] !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL ram_drained: got %h expected %h", dut.ram_q[4], 32'h1234_5678);
    end
    do_cycle(1'b1, 1'b0, 32'h10, 32'h0);
    vectors++;
    if (bus_seen !== 32'h1234_5678) begin
      miscompares++;
      $display("FAIL ram_read_from_array: got %h expected %h", bus_seen, 32'h1234_5678);
    end
  endtask

  task automatic test_forward_order();
    do_cycle(1'b0, 1'b1, 32'h20, 32'hA);
    do_cycle(1'b1, 1'b0, 32'h20, 32'h0);
    vectors++;
    if (bus_seen !== 32'hA) begin
      miscompares++;
      $display("FAIL fwd_first: got %h expected %h", bus_seen, 32'hA);
    end
    do_cycle(1'b0, 1'b1, 32'h20, 32'hB);
    do_cycle(1'b1, 1'b0, 32'h20, 32'h0);
    vectors++;
    if (bus_seen !== 32'hB) begin
      miscompares++;
      $display("FAIL fwd_newest: got %h expected %h", bus_seen, 32'hB);
    end
    idle(2);
    vectors++;
    if (dut.ram_q[8] !== 32'hB) begin
      miscompares++;
      $display("FAIL fwd_ram8: got %h expected %h", dut.ram_q[8], 32'hB);
    end
  endtask

  task automatic test_io();
    do_cycle(1'b0, 1'b1, 32'hF000_0000, 32'hFFFF_00AA);
    vectors++;
    if (io_led !== 16'h00AA) begin
      miscompares++;
      $display("FAIL io_led_write: got %h expected %h", io_led, 16'h00AA);
    end
    do_cycle(1'b1, 1'b0, 32'hF000_0000, 32'h0);
    vectors++;
    if (bus_seen !== 32'h0000_00AA) begin
      miscompares++;
      $display("FAIL io_led_read: got %h expected %h", bus_seen, 32'h0000_00AA);
    end
    io_sw = 16'h1234;
    idle(2);
    do_cycle(1'b1, 1'b0, 32'hF000_0004, 32'h0);
    vectors++;
    if (bus_seen !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL io_sw_read: got %h expected %h", bus_seen, 32'h0000_1234);
    end
    do_cycle(1'b0, 1'b1, 32'hF000_0004, 32'hFFFF_FFFF);
    do_cycle(1'b1, 1'b0, 32'hF000_0004, 32'h0);
    vectors++;
    if (bus_seen !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL io_sw_write_ignored: got %h expected %h", bus_seen, 32'h0000_1234);
    end
    do_cycle(1'b0, 1'b1, 32'hF000_0008, 32'h1234_5678);
    idle(5);
    do_cycle(1'b1, 1'b0, 32'hF000_0008, 32'h0);
    vectors++;
    if (bus_seen !== 32'd5) begin
      miscompares++;
      $display("FAIL io_counter_clear: got %h expected %h", bus_seen, 32'd5);
    end
    do_cycle(1'b0, 1'b1, 32'hF000_000C, 32'hDEAD_BEEF);
    do_cycle(1'b1, 1'b0, 32'hF000_000C, 32'h0);
    vectors++;
    if (bus_seen !== 32'h0) begin
      miscompares++;
      $display("FAIL io_unmapped: got %h expected %h", bus_seen, 32'h0);
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [8];
    logic [31:0]   a, d;
    logic          rd, wr;
    int            r;
    for (int i = 0; i < 8; i++) begin
      pool[i] = AW'($urandom_range(16, (1 << AW) - 1));
      do_cycle(1'b0, 1'b1, {20'h0, pool[i], 2'b00}, $urandom);
    end
    idle(3);
    for (int n = 0; n < 400; n++) begin
      r  = int'($urandom_range(0, 99));
      rd = (r < 45) || (r >= 90);
      wr = (r >= 45 && r < 80) || (r >= 90);
      if ($urandom_range(0, 4) == 0)
        a = {4'hF, 24'h0, 2'($urandom_range(0, 3)), 2'b00};
      else
        a = {4'($urandom_range(0, 14)), 16'($urandom), pool[$urandom_range(0, 7)], 2'($urandom)};
      d = $urandom;
      if ($urandom_range(0, 9) == 0) io_sw = 16'($urandom);
      do_cycle(rd, wr, a, d);
      if (rd && !wr) begin
        vectors++;
        if (bus_seen !== exp_bus) begin
          miscompares++;
          $display("FAIL rand_read n=%0d addr=%h: got %h expected %h", n, a, bus_seen, exp_bus);
        end
      end
      vectors++;
      if (io_led !== led_m || wb_ovf !== ovf_m) begin
        miscompares++;
        $display("FAIL rand_regs n=%0d: got led=%h ovf=%b expected led=%h ovf=%b",
                 n, io_led, wb_ovf, led_m, ovf_m);
      end
    end
    idle(4);
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (dut.ram_q[pool[i]] !== ram_m[int'(pool[i])]) begin
        miscompares++;
        $display("FAIL rand_ram_final idx=%0d: got %h expected %h",
                 pool[i], dut.ram_q[pool[i]], ram_m[int'(pool[i])]);
      end
    end
  endtask

  task automatic test_overflow();
    do_cycle(1'b0, 1'b1, 32'h100, 32'h1111_0000);
    do_cycle(1'b0, 1'b1, 32'h104, 32'h2222_0000);
    do_cycle(1'b0, 1'b1, 32'h108, 32'h3333_0000);
    idle(3);
    do_cycle(1'b1, 1'b1, 32'h100, 32'hAAAA_0001);
    do_cycle(1'b1, 1'b1, 32'h104, 32'hAAAA_0002);
    do_cycle(1'b1, 1'b1, 32'h108, 32'hAAAA_0003);
    vectors++;
    if (wb_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag: got %b expected 1", wb_ovf);
    end
    do_cycle(1'b1, 1'b0, 32'h108, 32'h0);
    vectors++;
    if (bus_seen !== 32'h3333_0000) begin
      miscompares++;
      $display("FAIL ovf_third_dropped: got %h expected %h", bus_seen, 32'h3333_0000);
    end
    do_cycle(1'b1, 1'b0, 32'h104, 32'h0);
    vectors++;
    if (bus_seen !== 32'hAAAA_0002) begin
      miscompares++;
      $display("FAIL ovf_second_forwarded: got %h expected %h", bus_seen, 32'hAAAA_0002);
    end
    idle(1);
    vectors++;
    if (dut.ram_q[64] !== 32'hAAAA_0001 || dut.ram_q[65] !== 32'h2222_0000) begin
      miscompares++;
      $display("FAIL ovf_drain_first: got %h/%h expected %h/%h",
               dut.ram_q[64], dut.ram_q[65], 32'hAAAA_0001, 32'h2222_0000);
    end
    idle(1);
    vectors++;
    if (dut.ram_q[65] !== 32'hAAAA_0002 || dut.ram_q[66] !== 32'h3333_0000) begin
      miscompares++;
      $display("FAIL ovf_drain_second: got %h/%h expected %h/%h",
               dut.ram_q[65], dut.ram_q[66], 32'hAAAA_0002, 32'h3333_0000);
    end
  endtask

  task automatic test_illegal_reset();
    do_cycle(1'b0, 1'b1, 32'h300, 32'h0F0F_C3C3);
    do_cycle(1'b0, 1'b1, 32'h304, 32'h0BAD_F00D);
    idle(3);
    do_cycle(1'b1, 1'b1, 32'h300, 32'hF0F0_3C3C);
    vectors++;
    if (bus_seen !== 32'hF0F0_3C3C) begin
      miscompares++;
      $display("FAIL illegal_bus_not_driven: got %h expected %h", bus_seen, 32'hF0F0_3C3C);
    end
    vectors++;
    if (wb_ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_ovf: got %b expected 1", wb_ovf);
    end
    idle(1);
    do_cycle(1'b0, 1'b1, 32'h304, 32'hDEAD_0304);
    Memread = 1'b0; Memwrite = 1'b0; tb_oe = 1'b0;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (wb_ovf !== 1'b0 || io_led !== 16'h0) begin
      miscompares++;
      $display("FAIL async_reset: got ovf=%b led=%h expected ovf=0 led=0000", wb_ovf, io_led);
    end
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    model_edge(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    do_cycle(1'b1, 1'b0, 32'h304, 32'h0);
    vectors++;
    if (bus_seen !== 32'h0BAD_F00D) begin
      miscompares++;
      $display("FAIL reset_discards_pending: got %h expected %h", bus_seen, 32'h0BAD_F00D);
    end
    do_cycle(1'b1, 1'b0, 32'h300, 32'h0);
    vectors++;
    if (bus_seen !== 32'hF0F0_3C3C) begin
      miscompares++;
      $display("FAIL illegal_write_kept: got %h expected %h", bus_seen, 32'hF0F0_3C3C);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    Memread = 1'b0; Memwrite = 1'b0; Addr = 32'h0;
    tb_oe = 1'b0; tb_dout = 32'h0; io_sw = 16'h0; rst = 1'b0;
    ram_m.delete();
    model_reset();
    test_reset();
    test_ram_rw();
    test_forward_order();
    test_io();
    test_random();
    test_overflow();
    test_illegal_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
